// File: rtl/alu_result_pkg.sv
// Shared types and constants for the ALU result/display stage.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package alu_result_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LATCH = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry 15 first, entry 0 last.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/alu_result_stage_hex_to_7seg.sv
// Hex nibble to active-low 7-segment pattern.
// Purely combinational lookup into the shared table.
module hex_to_7seg
  import alu_result_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/alu_result_stage.sv
// Captures ALU result, registers flags one cycle later,
// and scans the held value onto a muxed 7-segment display.
module alu_result_stage
  import alu_result_pkg::*;
#(
  parameter  int N           = 4,
  parameter  int REFRESH_DIV = 50000,
  localparam int DIGITS      = (2*N+3)/4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic              sel_wide,
  input  logic [N-1:0]      result,
  input  logic [2*N-1:0]    multi_result,
  input  logic              carry,
  output logic              ready,
  output logic [2*N-1:0]    value_q,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV-1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS-1);

  state_t state_q, state_d;
  logic   accept;
  logic   wide_q;
  logic   carry_q;

  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;

  logic [4*DIGITS-1:0] val_pad;
  logic [3:0]          nibble;
  logic [6:0]          seg_raw;
  logic [DIGITS-1:0]   an_show;
  logic                show;

  assign ready  = (state_q != LATCH);
  assign accept = load && !clr && ready;
  assign show   = (state_q == SHOW);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY,
      SHOW:    if (accept) state_d = LATCH;
      LATCH:   state_d = SHOW;
      default: state_d = EMPTY;
    endcase
    if (clr) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      wide_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (clr) begin
      value_q <= '0;
      wide_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (accept) begin
      value_q <= sel_wide ? multi_result
                          : {{N{1'b0}}, result};
      wide_q  <= sel_wide;
      carry_q <= carry;
    end
  end

  // Flags follow value_q by one cycle, taken in LATCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else if (clr) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else if (state_q == LATCH) begin
      flag_z <= (value_q == '0);
      flag_n <= wide_q ? value_q[2*N-1] : value_q[N-1];
      flag_c <= wide_q ? 1'b0 : carry_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    val_pad = '0;
    val_pad[2*N-1:0] = value_q;
    nibble = '0;
    an_show = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nibble     = val_pad[4*i +: 4];
        an_show[i] = 1'b0;
      end
    end
  end

  hex_to_7seg u_hex (
    .nib (nibble),
    .seg (seg_raw)
  );

  assign seg = show ? seg_raw : SEG_BLANK;
  assign an  = show ? an_show : '1;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage (N=4, REFRESH_DIV=4).
// Driver pushes expected value/flags; monitor pops on ready rise.
module tb_alu_result_stage;

  typedef struct {
    logic [7:0] v;
    logic       z;
    logic       n;
    logic       c;
  } exp_t;

  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S5 = 7'h12;
  localparam logic [6:0] SA = 7'h08;
  localparam logic [6:0] SE = 7'h06;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic       clr;
  logic       sel_wide;
  logic [3:0] result;
  logic [7:0] multi_result;
  logic       carry;
  logic       ready;
  logic [7:0] value_q;
  logic       flag_z;
  logic       flag_n;
  logic       flag_c;
  logic [6:0] seg;
  logic [1:0] an;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  alu_result_stage #(
    .N           (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .clr          (clr),
    .sel_wide     (sel_wide),
    .result       (result),
    .multi_result (multi_result),
    .carry        (carry),
    .ready        (ready),
    .value_q      (value_q),
    .flag_z       (flag_z),
    .flag_n       (flag_n),
    .flag_c       (flag_c),
    .seg          (seg),
    .an           (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_an"}, 32'(an), 32'h3);
    check({tag, "_ready"}, 32'(ready), 32'h1);
    check({tag, "_value"}, 32'(value_q), 32'h0);
    check({tag, "_flags"}, {29'd0, flag_z, flag_n, flag_c}, 32'h0);
  endtask

  // Watch 16 cycles: one digit on, right nibble, 4 cycles each.
  task automatic check_scan(input logic [6:0] s0,
                            input logic [6:0] s1,
                            input string tag);
    logic [1:0] prev;
    logic [6:0] want;
    int run, changes, seg_bad, run_bad;
    prev = an;
    run = 1;
    changes = 0;
    seg_bad = 0;
    run_bad = 0;
    repeat (16) begin
      tick();
      want = (an == 2'b10) ? s0 : s1;
      if ((an != 2'b10 && an != 2'b01) || seg != want)
        seg_bad++;
      if (an == prev) begin
        run++;
      end else begin
        if (changes > 0 && run != 4) run_bad++;
        changes++;
        run = 1;
      end
      prev = an;
    end
    check({tag, "_digits_bad"}, 32'(seg_bad), 32'd0);
    check({tag, "_runs_bad"}, 32'(run_bad), 32'd0);
    check({tag, "_changes"}, 32'(changes), 32'd4);
  endtask

  // Monitor: flags become valid when ready returns high.
  initial begin
    logic prev_ready;
    exp_t e;
    prev_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ready = 1'b1;
      end else begin
        if (ready && !prev_ready) begin
          if (sb.size() == 0) begin
            check("sb_unexpected_result", 32'(value_q), 32'hFFFF);
          end else begin
            e = sb.pop_front();
            check("sb_value", 32'(value_q), 32'(e.v));
            check("sb_flag_z", 32'(flag_z), 32'(e.z));
            check("sb_flag_n", 32'(flag_n), 32'(e.n));
            check("sb_flag_c", 32'(flag_c), 32'(e.c));
          end
        end
        prev_ready = ready;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=done");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    clr = 1'b0;
    sel_wide = 1'b0;
    result = '0;
    multi_result = '0;
    carry = 1'b0;
    #2;
    check_reset_outs("por");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Narrow load: 0x0E, carry set.
    result = 4'hE;
    carry = 1'b1;
    sel_wide = 1'b0;
    load = 1'b1;
    sb.push_back('{8'h0E, 1'b0, 1'b1, 1'b1});
    tick();
    load = 1'b0;
    check("narrow_value", 32'(value_q), 32'h0E);
    check("narrow_ready_low", 32'(ready), 32'h0);
    check("narrow_latch_blank", 32'(an), 32'h3);
    tick();
    check("narrow_ready_back", 32'(ready), 32'h1);
    check("narrow_flags", {29'd0, flag_z, flag_n, flag_c}, 32'h3);
    check_scan(SE, S0, "narrow");

    // Wide load: 0xA5; carry must be dropped.
    multi_result = 8'hA5;
    sel_wide = 1'b1;
    carry = 1'b1;
    load = 1'b1;
    sb.push_back('{8'hA5, 1'b0, 1'b1, 1'b0});
    tick();
    load = 1'b0;
    check("wide_value", 32'(value_q), 32'hA5);
    tick();
    check("wide_flags", {29'd0, flag_z, flag_n, flag_c}, 32'h2);
    check_scan(S5, SA, "wide");

    // Zero result with load held: accepted every other edge.
    result = 4'h0;
    sel_wide = 1'b0;
    carry = 1'b0;
    load = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) sb.push_back('{8'h00, 1'b1, 1'b0, 1'b0});
      tick();
      check($sformatf("b2b_ready_%0d", i),
            32'(ready), (i % 2 == 0) ? 32'h0 : 32'h1);
      check($sformatf("b2b_value_%0d", i), 32'(value_q), 32'h0);
    end
    load = 1'b0;
    check("zero_flags", {29'd0, flag_z, flag_n, flag_c}, 32'h4);
    tick();

    // clr and load together in SHOW.
    result = 4'h3;
    load = 1'b1;
    clr = 1'b1;
    tick();
    load = 1'b0;
    clr = 1'b0;
    check_reset_outs("clr");
    tick();
    tick();
    check("clr_stay_blank_an", 32'(an), 32'h3);
    check("clr_stay_blank_seg", 32'(seg), 32'h7F);

    // Reset asserted mid-cycle while in LATCH.
    result = 4'h8;
    carry = 1'b1;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("latch_value", 32'(value_q), 32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst_latch");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_reset_outs("post_rst");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Output stage directly downstream of the 4-bit ALU. It captures either the ALU's N-bit result or its 2N-bit multiply result on a load handshake, and registers zero, negative and carry flags. It holds the value and drives it onto a time-multiplexed, active-low, common-anode 7-segment display, one hex digit per 4 bits. It turns the ALU's purely combinational outputs into a stable, observable board-level result.

## Interface
Parameters:
- N, 4, ALU operand width; must be ≥ 2.
- REFRESH_DIV, 50000, clock cycles each digit stays enabled; must be ≥ 2.
- DIGITS, (2*N+3)/4, derived localparam; the number of hex digits scanned (2 for N=4).

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  capture request; accepted only when ready=1.
- clr  in  1  synchronous clear to EMPTY; wins over load.
- sel_wide  in  1  1 = capture multi_result; 0 = capture result; sampled with load.
- result  in  N  ALU mux result.
- multi_result  in  2N  ALU multiply result.
- carry  in  1  ALU carry/borrow for the selected add/sub op; sampled with load.
- ready  out  1  1 when a load can be accepted.
- value_q  out  2N  captured value; narrow captures are zero-extended.
- flag_z, flag_n, flag_c  out  1 each  registered flags for value_q.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  DIGITS  digit enables, active-low; bit 0 = least significant hex digit.

## Operation
- FSM states are EMPTY, LATCH and SHOW.
- **EMPTY**: ready=1; all an bits are high (display blank).
- **Load in EMPTY or SHOW** (load=1, clr=0, ready=1):
  - value_q ← sel_wide ? multi_result : {N'b0, result}.
  - wide_q ← sel_wide; carry_q ← carry.
  - Next state is LATCH.
- **LATCH** (exactly 1 cycle): ready=0; load is ignored.
  - flag_z ← (value_q == 0).
  - flag_n ← wide_q ? value_q[2N-1] : value_q[N-1].
  - flag_c ← wide_q ? 0 : carry_q.
  - Next state is SHOW.
- **SHOW**: ready=1; digits are scanned. A new load re-enters LATCH.
- **clr=1 in any state**: next state is EMPTY; value_q and all flags go to 0. clr has priority over load in the same cycle.
- **Scan counter**:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index advances 0..DIGITS-1 and wraps to 0.
  - The counter runs in every state.
- In SHOW, an is all ones except bit[digit index], which is 0. seg shows the hex nibble value_q[4*idx+3:4*idx]. For the top digit when 2N is not a multiple of 4, the missing bits read as 0.
- In EMPTY and LATCH, seg = 7'h7F and an is all ones (blank while flags settle).

## Timing
- **Reset** (asynchronous, while rst_n=0):
  - State EMPTY; ready=1; value_q=0; all flags 0.
  - seg=7'h7F; an all ones; scan counter=0; digit index=0.
- **Load latency**, for a load accepted at edge k:
  - value_q is valid after edge k.
  - Flags are valid and ready=1 after edge k+1.
  - The display shows the new value from edge k+1 onward.
- **Throughput**: one load every 2 cycles. A load held high continuously is accepted every other cycle.
- **Digit timing**: each digit is enabled for exactly REFRESH_DIV cycles. Exactly one an bit is low at a time in SHOW. Digit-change and nibble-change occur on the same edge (no ghosting cycle).
- **Load in SHOW mid-scan** does not reset the scan counter or digit index.
- **Reset mid-LATCH** returns to EMPTY with no flag update.

## Structure
- Package alu_result_pkg holds:
  - typedef enum state_t {EMPTY, LATCH, SHOW};
  - the 16-entry active-low hex-to-segment constant table;
  - SEG_BLANK = 7'h7F.
- Sub-module hex_to_7seg: combinational, 4-bit nibble in, 7-bit seg out, using the package table.
- Top level holds the FSM, capture/flag registers, scan counter, digit index and nibble mux.

## Test plan
Use N=4, REFRESH_DIV=4.
- **Reset**: assert rst_n=0 mid-cycle. Required: seg=7'h7F, an=2'b11, ready=1 and value_q=0 immediately, without waiting for a clock edge.
- **Narrow load**: result=4'hE, carry=1, sel_wide=0, 1-cycle load. Required:
  - value_q=8'h0E after the same edge; ready=0 for one cycle.
  - Then flag_n=1, flag_c=1, flag_z=0.
  - an alternates 2'b10 with seg=hex E and 2'b01 with seg=hex 0, every 4 cycles.
- **Wide load**: multi_result=8'hA5, sel_wide=1, carry=1. Required:
  - flag_c=0, flag_n=1, flag_z=0.
  - Digit 0 shows 5 and digit 1 shows A.
- **Zero/back-to-back**: load result=0, then hold load=1. Required:
  - flag_z=1, flag_n=0.
  - Loads are accepted on every other edge only; ready toggles 1,0,1,0.
- **clr+load same cycle** while in SHOW. Required: state EMPTY, value_q=0, display blank, load discarded.
- **Reset during LATCH**. Required: all outputs at reset values; flags remain 0 after release.
